seg7_scan_mux: RTL and testbench

Parametrised multiplexed seven-segment display driver, the successor to the fixed 4-digit `dis` scanner. It time-multiplexes `DIGITS` hex digits onto one shared segment bus and adds a programmable refresh prescaler, per-digit decimal points, leading-zero blanking, PWM brightness and a tear-free load handshake. It sits between a register or status source and the board-level display pins.

---
 rtl/seg7_scan_mux.sv | 222 ++++++++++++++++++++++
 tb/tb_seg7_scan_mux.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - multiplexed seven-segment scanner with buffered load, LZ blanking and PWM
//
// Time-multiplexes DIGITS hex digits onto one shared segment bus.
//
// Parameters
//   DIGITS     number of digits scanned (>= 2)
//   CLK_DIV    clk cycles per prescaler tick (>= 2)
//   BRIGHT_W   brightness width; one digit slot lasts 2**BRIGHT_W ticks
//   ACTIVE_LOW nonzero inverts seg, dp and digit_select at the pins
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   load         one-cycle strobe capturing data_in/dp_in/blank_lz into the pending set
//   data_in      hex nibbles, nibble i = data_in[4i+3:4i], digit 0 rightmost
//   dp_in        decimal point per digit
//   blank_lz     leading-zero blanking enable
//   bright       on-time per slot, sampled live
//   seg          segments {g,f,e,d,c,b,a}, registered
//   dp           decimal point, registered
//   digit_select one-hot digit enable, registered
//   frame_done   one-cycle pulse after each frame boundary
module seg7_scan_mux #(
    parameter int DIGITS     = 4,
    parameter int CLK_DIV    = 2,
    parameter int BRIGHT_W   = 2,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     digit_select,
    output logic                  frame_done
);

    localparam int PCNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PCNT_W-1:0]   PCNT_LAST  = PCNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [BRIGHT_W-1:0] PHASE_LAST = {BRIGHT_W{1'b1}};

    // Pin polarity masks, XORed onto the active-high internal values
    localparam logic              POL      = (ACTIVE_LOW != 0);
    localparam logic [6:0]        SEG_POL  = {7{POL}};
    localparam logic              DP_POL   = POL;
    localparam logic [DIGITS-1:0] SEL_POL  = {DIGITS{POL}};

    // Scan counters
    logic [PCNT_W-1:0]   pcnt_q,  pcnt_d;
    logic [BRIGHT_W-1:0] phase_q, phase_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;

    // Pending and active display sets
    logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
    logic [DIGITS-1:0]   pend_dp_q,   pend_dp_d;
    logic                pend_blz_q,  pend_blz_d;
    logic                pend_valid_q, pend_valid_d;
    logic [4*DIGITS-1:0] act_data_q,  act_data_d;
    logic [DIGITS-1:0]   act_dp_q,    act_dp_d;
    logic                act_blz_q,   act_blz_d;

    // Output registers
    logic [6:0]          seg_q, seg_d;
    logic                dp_q,  dp_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic                fd_q,  fd_d;

    logic tick;
    logic slot_end;
    logic boundary;

    logic [DIGITS-1:0]   blank_mask;
    logic                lz_run;

    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic [DIGITS-1:0]   cur_onehot;
    logic                lit;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Tick / slot / frame timing
    always_comb begin
        tick     = (pcnt_q == PCNT_LAST);
        slot_end = tick && (phase_q == PHASE_LAST);
        boundary = slot_end && (idx_q == IDX_LAST);

        pcnt_d  = tick ? '0 : pcnt_q + 1'b1;
        phase_d = tick ? phase_q + 1'b1 : phase_q;
        idx_d   = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Double buffer. The boundary copy reads the old pending contents, so a
    // load landing on the boundary edge is held back for the following frame.
    always_comb begin
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blz_d   = pend_blz_q;
        pend_valid_d = pend_valid_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_blz_d    = act_blz_q;

        if (boundary && pend_valid_q) begin
            act_data_d   = pend_data_q;
            act_dp_d     = pend_dp_q;
            act_blz_d    = pend_blz_q;
            pend_valid_d = 1'b0;
        end
        if (load) begin
            pend_data_d  = data_in;
            pend_dp_d    = dp_in;
            pend_blz_d   = blank_lz;
            pend_valid_d = 1'b1;
        end
    end

    // Leading-zero mask: walk down from the top digit while nibbles are zero.
    // Digit 0 is never part of the run so a value of zero still shows "0".
    always_comb begin
        blank_mask = '0;
        lz_run     = act_blz_q;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz_run        = lz_run && (act_data_q[4*i +: 4] == 4'h0);
            blank_mask[i] = lz_run;
        end
    end

    // Current-digit select and output next-state
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib       = act_data_q[4*i +: 4];
                cur_dp        = act_dp_q[i];
                cur_blank     = blank_mask[i];
                cur_onehot[i] = 1'b1;
            end
        end

        lit   = (phase_q <= bright);
        seg_d = SEG_POL ^ ((lit && !cur_blank) ? hex7(cur_nib) : 7'h00);
        dp_d  = DP_POL ^ (lit && cur_dp);
        sel_d = SEL_POL ^ (lit ? cur_onehot : '0);
        fd_d  = boundary;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q       <= '0;
            phase_q      <= '0;
            idx_q        <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blz_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blz_q    <= 1'b0;
            seg_q        <= SEG_POL;
            dp_q         <= DP_POL;
            sel_q        <= SEL_POL;
            fd_q         <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blz_q   <= pend_blz_d;
            pend_valid_q <= pend_valid_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blz_q    <= act_blz_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            sel_q        <= sel_d;
            fd_q         <= fd_d;
        end
    end

    assign seg          = seg_q;
    assign dp           = dp_q;
    assign digit_select = sel_q;
    assign frame_done   = fd_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - directed self-checking bench for seg7_scan_mux
module tb_seg7_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [1:0]  bright;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  sel;
    logic        fd;

    logic        rst1;
    logic        load1;
    logic [23:0] data1;
    logic [5:0]  dpin1;
    logic        blz1;
    logic [1:0]  bright1;
    logic [6:0]  seg1;
    logic        dp1;
    logic [5:0]  sel1;
    logic        fd1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg7_scan_mux u0 (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
        .blank_lz(blank_lz), .bright(bright), .seg(seg), .dp(dp),
        .digit_select(sel), .frame_done(fd)
    );

    seg7_scan_mux #(.DIGITS(6), .ACTIVE_LOW(1)) u1 (
        .clk(clk), .rst(rst1), .load(load1), .data_in(data1), .dp_in(dpin1),
        .blank_lz(blz1), .bright(bright1), .seg(seg1), .dp(dp1),
        .digit_select(sel1), .frame_done(fd1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic b);
        data_in  = d;
        dp_in    = p;
        blank_lz = b;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    task automatic wait_fd();
        int k = 0;
        while (fd !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        chk("fd_seen", 32'(fd), 32'(1'b1));
    endtask

    task automatic wait_fd1();
        int k = 0;
        while (fd1 !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        chk("fd1_seen", 32'(fd1), 32'(1'b1));
    endtask

    // Called right after a frame_done sample; steps through one whole frame
    // and leaves the bench on the next frame_done sample.
    task automatic check_frame(input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3,
                               input logic [3:0] pexp, input int on_cyc);
        logic [6:0]  e [4];
        logic [12:0] got, exp;
        logic        lit;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                step();
                lit = (c < on_cyc);
                got = {fd, dp, sel, seg};
                exp = {(s == 3 && c == 7), lit && pexp[s],
                       lit ? 4'(1 << s) : 4'h0, lit ? e[s] : 7'h00};
                chk($sformatf("frame d%0d c%0d {fd,dp,sel,seg}", s, c), 32'(got), 32'(exp));
            end
        end
    endtask

    initial begin
        logic [14:0] got1, exp1;
        rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; blank_lz = 1'b0; bright = 2'd3;
        rst1 = 1'b1; load1 = 1'b0; data1 = '0; dpin1 = '0; blz1 = 1'b0; bright1 = 2'd3;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel", 32'(sel), 32'(4'h0));
        chk("rst_seg", 32'(seg), 32'(7'h00));
        chk("rst_dp",  32'(dp),  32'(1'b0));
        chk("rst_fd",  32'(fd),  32'(1'b0));
        rst = 1'b0;
        step();
        chk("first_sel", 32'(sel), 32'(4'h1));
        chk("first_seg", 32'(seg), 32'(7'h3F));

        // Load and scan order
        do_load(16'h1234, 4'h0, 1'b0);
        wait_fd();
        check_frame(7'h66, 7'h4F, 7'h5B, 7'h06, 4'h0, 8);

        // Leading-zero blanking
        do_load(16'h0090, 4'h0, 1'b1);
        wait_fd();
        check_frame(7'h3F, 7'h6F, 7'h00, 7'h00, 4'h0, 8);
        do_load(16'h0000, 4'b1010, 1'b1);
        wait_fd();
        check_frame(7'h3F, 7'h00, 7'h00, 7'h00, 4'b1010, 8);

        // Tear-free load: mid-frame load, then another on the boundary edge
        do_load(16'h5678, 4'h0, 1'b1);
        repeat (30) step();
        chk("tear_old {dp,sel,seg}", 32'({dp, sel, seg}), 32'({1'b1, 4'b1000, 7'h00}));
        data_in = 16'h0901; dp_in = 4'h0; blank_lz = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        chk("tear_fd", 32'(fd), 32'(1'b1));
        check_frame(7'h7F, 7'h07, 7'h7D, 7'h6D, 4'h0, 8);
        check_frame(7'h06, 7'h3F, 7'h6F, 7'h00, 4'h0, 8);

        // Brightness
        bright = 2'd0;
        check_frame(7'h06, 7'h3F, 7'h6F, 7'h00, 4'h0, 2);
        bright = 2'd1;
        check_frame(7'h06, 7'h3F, 7'h6F, 7'h00, 4'h0, 4);
        bright = 2'd3;

        // Reset mid-scan with pending data outstanding
        do_load(16'h1111, 4'hF, 1'b0);
        repeat (5) step();
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_sel", 32'(sel), 32'(4'h0));
        chk("midrst_seg", 32'(seg), 32'(7'h00));
        chk("midrst_dp",  32'(dp),  32'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("postrst_sel", 32'(sel), 32'(4'h1));
        chk("postrst_seg", 32'(seg), 32'(7'h3F));
        wait_fd();
        check_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'h0, 8);

        // Active-low, six-digit build
        chk("al_rst_sel", 32'(sel1), 32'(6'h3F));
        chk("al_rst_seg", 32'(seg1), 32'(7'h7F));
        chk("al_rst_dp",  32'(dp1),  32'(1'b1));
        rst1 = 1'b0;
        step();
        chk("al_first_sel", 32'(sel1), 32'(6'b111110));
        chk("al_first_seg", 32'(seg1), 32'(7'h40));
        data1 = 24'h888888; dpin1 = 6'b000100; blz1 = 1'b0; load1 = 1'b1;
        step();
        load1 = 1'b0;
        wait_fd1();
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < 8; c++) begin
                step();
                got1 = {fd1, dp1, sel1, seg1};
                exp1 = {(s == 5 && c == 7), (s != 2), ~6'(1 << s), 7'h00};
                chk($sformatf("al d%0d c%0d {fd,dp,sel,seg}", s, c), 32'(got1), 32'(exp1));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
